// File: rtl/coreport_mc.sv
// Wishbone GPIO port: synchronised pad inputs, per-pin edge/level interrupts,
// W1C flags and atomic set/clear/toggle of the output latch.

module coreport_mc_pin (
    input  logic s,
    input  logic s_d,
    input  logic gate,
    input  logic ier,
    input  logic ipr,
    input  logic ibe,
    output logic evt
);
    logic rise, fall, edge_hit, lvl_hit;

    assign rise     = s & ~s_d;
    assign fall     = ~s & s_d;
    // Both-edges mode overrides polarity, but only in edge mode.
    assign edge_hit = ibe ? (rise | fall) : (ipr ? rise : fall);
    assign lvl_hit  = (s == ipr);
    assign evt      = gate & (ier ? edge_hit : lvl_hit);
endmodule

module coreport_mc #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic [2:0]       wb_cti_i,
    input  logic [1:0]       wb_bte_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic             wb_rty_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    localparam logic [7:0] A_DATA = 8'h00, A_DDR = 8'h04, A_IMR = 8'h08, A_IFR = 8'h0C,
                           A_IER  = 8'h10, A_IPR = 8'h14, A_IBE = 8'h18, A_SET = 8'h1C,
                           A_CLR  = 8'h20, A_TGL = 8'h24;

    logic [WIDTH-1:0] latch, ddr, imr, ifr, ier, ipr, ibe;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] s, s_d, evt, rd_w, bm, wdm, w1c;
    logic [31:0]      bmask;
    logic [7:0]       off;
    logic             accept, mapped, wr_en;
    logic             unused_bits;

    assign unused_bits = ^{wb_adr_i[31:8], wb_cti_i, wb_bte_i, wb_dat_i, bmask};

    assign off     = wb_adr_i[7:0];
    assign accept  = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign wr_en   = accept & wb_we_i & mapped;
    assign bmask   = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign bm      = bmask[WIDTH-1:0];
    assign wdm     = wb_dat_i[WIDTH-1:0] & bm;
    assign w1c     = (wr_en && off == A_IFR) ? wdm : '0;
    assign s       = sync_q[SYNC_STAGES-1];
    assign gpio_o  = latch;
    assign gpio_oe = ddr;
    assign wb_rty_o = 1'b0;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync_q <= '0;
            s_d    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
            s_d    <= s;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        coreport_mc_pin u_pin (
            .s    (s[i]),
            .s_d  (s_d[i]),
            .gate (imr[i] & ~ddr[i]),
            .ier  (ier[i]),
            .ipr  (ipr[i]),
            .ibe  (ibe[i]),
            .evt  (evt[i])
        );
    end

    always_comb begin
        mapped = 1'b1;
        rd_w   = '0;
        case (off)
            A_DATA: rd_w = (ddr & latch) | (~ddr & s);
            A_DDR:  rd_w = ddr;
            A_IMR:  rd_w = imr;
            A_IFR:  rd_w = ifr;
            A_IER:  rd_w = ier;
            A_IPR:  rd_w = ipr;
            A_IBE:  rd_w = ibe;
            A_SET, A_CLR, A_TGL: rd_w = '0;
            default: mapped = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            latch <= '0;
            ddr   <= '0;
            imr   <= '0;
            ier   <= '0;
            ipr   <= '0;
            ibe   <= '0;
        end else if (wr_en) begin
            case (off)
                A_DATA: latch <= (latch & ~bm) | wdm;
                A_DDR:  ddr   <= (ddr & ~bm) | wdm;
                A_IMR:  imr   <= (imr & ~bm) | wdm;
                A_IER:  ier   <= (ier & ~bm) | wdm;
                A_IPR:  ipr   <= (ipr & ~bm) | wdm;
                A_IBE:  ibe   <= (ibe & ~bm) | wdm;
                A_SET:  latch <= latch | wdm;
                A_CLR:  latch <= latch & ~wdm;
                A_TGL:  latch <= latch ^ wdm;
                default: ;
            endcase
        end
    end

    // A new event wins over a same-cycle clear so no edge is lost.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ifr <= '0;
            irq <= 1'b0;
        end else begin
            ifr <= (ifr & ~w1c) | evt;
            irq <= |(ifr & imr);
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
        end else begin
            wb_ack_o <= accept & mapped;
            wb_err_o <= accept & ~mapped;
            if (accept) wb_dat_o <= 32'(rd_w);
        end
    end
endmodule

// File: tb/tb_coreport_mc.sv
// Directed bench for coreport_mc: WIDTH=32 and WIDTH=8 instances share one bus.

module tb_coreport_mc;
    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic [31:0] adr = '0, dat = '0;
    logic [3:0]  wsel = '0;
    logic        we_i = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic [31:0] gpio_in = '0;

    logic [31:0] dat32, gpo32, oe32;
    logic        ack32, err32, rty32, irq32;
    logic [31:0] dat8;
    logic [7:0]  gpo8, oe8;
    logic        ack8, err8, rty8, irq8;

    int checks = 0;
    int failures = 0;

    always #5 wb_clk = ~wb_clk;

    coreport_mc #(.WIDTH(32), .SYNC_STAGES(2)) dut32 (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_adr_i(adr), .wb_dat_i(dat),
        .wb_sel_i(wsel), .wb_we_i(we_i), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_cti_i(3'b000), .wb_bte_i(2'b00), .wb_dat_o(dat32), .wb_ack_o(ack32),
        .wb_err_o(err32), .wb_rty_o(rty32), .gpio_i(gpio_in), .gpio_o(gpo32),
        .gpio_oe(oe32), .irq(irq32)
    );

    coreport_mc #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_adr_i(adr), .wb_dat_i(dat),
        .wb_sel_i(wsel), .wb_we_i(we_i), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_cti_i(3'b000), .wb_bte_i(2'b00), .wb_dat_o(dat8), .wb_ack_o(ack8),
        .wb_err_o(err8), .wb_rty_o(rty8), .gpio_i(gpio_in[7:0]), .gpio_o(gpo8),
        .gpio_oe(oe8), .irq(irq8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One classic cycle; strobe is held until ack/err or an 8-cycle budget runs out.
    task automatic wb_xfer(input logic [7:0] a, input logic [31:0] d, input logic [3:0] sel,
                           input logic we, output logic [31:0] rd, output logic [31:0] rd8,
                           output logic ak, output logic er);
        int n;
        @(negedge wb_clk);
        adr = {24'h0, a}; dat = d; wsel = sel; we_i = we; cyc = 1'b1; stb = 1'b1;
        n = 0;
        do begin
            @(posedge wb_clk); #1; n++;
        end while (!(ack32 || err32) && n < 8);
        rd = dat32; rd8 = dat8; ak = ack32; er = err32;
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
    endtask

    task automatic wb_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] r, r8;
        logic ak, er;
        wb_xfer(a, d, sel, 1'b1, r, r8, ak, er);
        chk($sformatf("wr_ack@%h", a), {31'b0, ak}, 32'd1);
    endtask

    task automatic wb_rd_chk(input logic [7:0] a, input logic [31:0] exp, input logic [31:0] exp8);
        logic [31:0] r, r8;
        logic ak, er;
        wb_xfer(a, 32'h0, 4'hF, 1'b0, r, r8, ak, er);
        chk($sformatf("rd_ack@%h", a), {31'b0, ak}, 32'd1);
        chk($sformatf("rd32@%h", a), r, exp);
        chk($sformatf("rd8@%h", a), r8, exp8);
    endtask

    logic [7:0] offs [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24};

    initial begin
        logic [31:0] r, r8;
        logic ak, er;
        int cnt;

        #1;
        chk("rst_gpo32", gpo32, 32'h0);
        chk("rst_oe32", oe32, 32'h0);
        chk("rst_flags32", {28'h0, ack32, err32, rty32, irq32}, 32'h0);
        chk("rst_out8", {8'h0, gpo8, oe8, 4'h0, ack8, err8, rty8, irq8}, 32'h0);
        repeat (3) @(posedge wb_clk);
        @(negedge wb_clk) wb_rst_n = 1'b1;

        foreach (offs[i]) wb_rd_chk(offs[i], 32'h0, 32'h0);

        // All-ones sweep. DATA reads pins while DDR=0; IFR is W1C; SET/CLR/TGL read 0.
        wb_wr(8'h00, 32'hFFFF_FFFF, 4'hF); wb_rd_chk(8'h00, 32'h0, 32'h0);
        wb_wr(8'h04, 32'hFFFF_FFFF, 4'hF); wb_rd_chk(8'h04, 32'hFFFF_FFFF, 32'hFF);
        wb_wr(8'h08, 32'hFFFF_FFFF, 4'hF); wb_rd_chk(8'h08, 32'hFFFF_FFFF, 32'hFF);
        wb_wr(8'h0C, 32'hFFFF_FFFF, 4'hF); wb_rd_chk(8'h0C, 32'h0, 32'h0);
        wb_wr(8'h10, 32'hFFFF_FFFF, 4'hF); wb_rd_chk(8'h10, 32'hFFFF_FFFF, 32'hFF);
        wb_wr(8'h14, 32'hFFFF_FFFF, 4'hF); wb_rd_chk(8'h14, 32'hFFFF_FFFF, 32'hFF);
        wb_wr(8'h18, 32'hFFFF_FFFF, 4'hF); wb_rd_chk(8'h18, 32'hFFFF_FFFF, 32'hFF);
        wb_wr(8'h1C, 32'hFFFF_FFFF, 4'hF); wb_rd_chk(8'h1C, 32'h0, 32'h0);
        wb_wr(8'h20, 32'hFFFF_FFFF, 4'hF); wb_rd_chk(8'h20, 32'h0, 32'h0);
        wb_wr(8'h24, 32'hFFFF_FFFF, 4'hF); wb_rd_chk(8'h24, 32'h0, 32'h0);
        wb_rd_chk(8'h00, 32'hFFFF_FFFF, 32'hFF);
        chk("sweep_gpo32", gpo32, 32'hFFFF_FFFF);
        chk("sweep_oe8", {24'h0, oe8}, 32'hFF);
        chk("sweep_irq", {31'b0, irq32}, 32'h0);
        foreach (offs[i]) if (offs[i] != 8'h0C) wb_wr(offs[i], 32'h0, 4'hF);

        // Atomic output ops
        wb_wr(8'h04, 32'h0000_00FF, 4'hF);
        wb_wr(8'h00, 32'h0000_00A5, 4'hF); chk("data_a5", gpo32, 32'hA5);
        chk("oe_ff", oe32, 32'hFF);
        wb_wr(8'h1C, 32'h0000_000A, 4'hF); chk("set_0a", gpo32, 32'hAF);
        wb_wr(8'h20, 32'h0000_0001, 4'hF); chk("clr_01", gpo32, 32'hAE);
        wb_wr(8'h24, 32'h0000_00F0, 4'hF); chk("tgl_f0", gpo32, 32'h5E);
        wb_wr(8'h00, 32'h0, 4'hF);
        wb_wr(8'h00, 32'h1234_5678, 4'b0010); chk("sel_byte1", gpo32, 32'h0000_5600);
        wb_rd_chk(8'h00, 32'h0, 32'h0);

        // Rising-edge interrupt on pin 3
        wb_wr(8'h04, 32'h0, 4'hF);
        wb_wr(8'h10, 32'h8, 4'hF);
        wb_wr(8'h14, 32'h8, 4'hF);
        wb_wr(8'h08, 32'h8, 4'hF);
        @(negedge wb_clk) gpio_in[3] = 1'b1;
        repeat (3) @(posedge wb_clk);
        #1 chk("irq_edge3", {31'b0, irq32}, 32'h0);
        @(posedge wb_clk);
        #1 chk("irq_edge4", {31'b0, irq32}, 32'h1);
        wb_rd_chk(8'h0C, 32'h8, 32'h8);
        wb_wr(8'h0C, 32'h8, 4'hF);
        @(posedge wb_clk);
        #1 chk("irq_cleared", {31'b0, irq32}, 32'h0);
        @(negedge wb_clk) gpio_in[3] = 1'b0;
        repeat (6) @(posedge wb_clk);
        wb_rd_chk(8'h0C, 32'h0, 32'h0);
        @(negedge wb_clk) gpio_in[3] = 1'b1;
        repeat (6) @(posedge wb_clk);
        wb_wr(8'h0C, 32'h8, 4'hF);
        wb_rd_chk(8'h0C, 32'h0, 32'h0);
        wb_wr(8'h18, 32'h8, 4'hF);
        @(negedge wb_clk) gpio_in[3] = 1'b0;
        repeat (6) @(posedge wb_clk);
        wb_rd_chk(8'h0C, 32'h8, 32'h8);
        foreach (offs[i]) if (offs[i] >= 8'h08 && offs[i] <= 8'h18 && offs[i] != 8'h0C)
            wb_wr(offs[i], 32'h0, 4'hF);
        wb_wr(8'h0C, 32'hFFFF_FFFF, 4'hF);

        // Level-low on pin 0, then a W1C landing on the edge-event cycle
        wb_wr(8'h08, 32'h1, 4'hF);
        wb_rd_chk(8'h0C, 32'h1, 32'h1);
        chk("irq_level", {31'b0, irq32}, 32'h1);
        wb_wr(8'h0C, 32'h1, 4'hF);
        wb_rd_chk(8'h0C, 32'h1, 32'h1);
        wb_wr(8'h14, 32'h1, 4'hF);
        wb_wr(8'h10, 32'h1, 4'hF);
        @(negedge wb_clk) gpio_in[0] = 1'b1;
        @(negedge wb_clk);
        wb_wr(8'h0C, 32'h1, 4'hF);
        wb_rd_chk(8'h0C, 32'h1, 32'h1);
        wb_wr(8'h0C, 32'h1, 4'hF);
        wb_rd_chk(8'h0C, 32'h0, 32'h0);
        wb_wr(8'h08, 32'h0, 4'hF);

        // Unmapped offsets
        wb_xfer(8'h28, 32'h0, 4'hF, 1'b0, r, r8, ak, er);
        chk("err28", {30'b0, ak, er}, 32'h1);
        chk("err28_dat", r, 32'h0);
        @(posedge wb_clk);
        #1 chk("err_pulse", {31'b0, err32}, 32'h0);
        wb_xfer(8'hFC, 32'hFFFF_FFFF, 4'hF, 1'b1, r, r8, ak, er);
        chk("errFC", {30'b0, ak, er}, 32'h1);
        wb_rd_chk(8'h04, 32'h0, 32'h0);
        chk("errFC_gpo", gpo32, 32'h0000_5600);

        // Held strobe: one ack every second cycle
        @(negedge wb_clk);
        adr = 32'h0; we_i = 1'b0; wsel = 4'hF; cyc = 1'b1; stb = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(posedge wb_clk); #1;
            if (ack32) cnt++;
        end
        cyc = 1'b0; stb = 1'b0;
        chk("held_acks", cnt, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/coreport_mc.md
# coreport_mc

Parametrised Wishbone GPIO port with separate pad signals, input synchronisation, per-pin edge/level interrupts with selectable polarity, write-1-to-clear flags, and atomic set/clear/toggle output registers. It is a 32-bit-bus slave on the peripheral Wishbone segment. Its pad-side outputs go to the chip-level IO cells, and its `irq` goes to the interrupt controller.

## Interface
- `WIDTH`, default 32: number of GPIO pins, 1..32. Register bits at and above `WIDTH` read 0 and ignore writes.
- `SYNC_STAGES`, default 2: input synchroniser depth, minimum 2.
- `wb_clk` input 1: the single clock.
- `wb_rst_n` input 1: asynchronous, active-low reset.
- `wb_adr_i` input 32: byte address; only `[7:0]` is decoded.
- `wb_dat_i` input 32: write data.
- `wb_sel_i` input 4: byte enables for writes.
- `wb_we_i`, `wb_cyc_i`, `wb_stb_i` input 1 each: classic Wishbone.
- `wb_cti_i` input 3, `wb_bte_i` input 2: ignored; every access is treated as classic.
- `wb_dat_o` output 32: registered read data.
- `wb_ack_o` output 1: registered acknowledge.
- `wb_err_o` output 1: registered error, for unmapped offsets.
- `wb_rty_o` output 1: tied 0.
- `gpio_i` input WIDTH: asynchronous pad inputs.
- `gpio_o` output WIDTH: output latch value.
- `gpio_oe` output WIDTH: output enable per pin; 1 = drive.
- `irq` output 1: registered interrupt request, level, active-high.

## Operation
Register map (byte offsets). All registers reset to 0.
- 0x00 `DATA`
  - Write: loads the output latch, byte-masked.
  - Read: per bit, `oe ? latch : synced_in`.
- 0x04 `DDR`: direction. 1 = output. Drives `gpio_oe`.
- 0x08 `IMR`: interrupt enable per pin.
- 0x0C `IFR`: interrupt flags. Read returns the flags. Writing 1 clears a bit; writing 0 has no effect.
- 0x10 `IER`: trigger type. 1 = edge, 0 = level.
- 0x14 `IPR`: polarity. 1 = rising/high, 0 = falling/low.
- 0x18 `IBE`: both edges. Effective only where IER=1, and overrides IPR there.
- 0x1C `SET`: `latch |= dat`.
- 0x20 `CLR`: `latch &= ~dat`.
- 0x24 `TGL`: `latch ^= dat`.
  - SET, CLR and TGL honour `wb_sel_i` and read as 0.
- Any other offset: the cycle ends with `wb_err_o` instead of ack and has no side effect. `wb_dat_o` reads 0.

Input path:
- `gpio_i` passes through a `SYNC_STAGES`-deep flop chain to give `s`.
- One more flop holds `s_d`.
- `rise = s & ~s_d`, `fall = ~s & s_d`.

Event per bit, gated by `IMR & ~DDR`:
- IER=0: event = `s == IPR`.
- IER=1, IBE=1: event = `rise | fall`.
- IER=1, IBE=0: event = IPR ? rise : fall.

Flag update each cycle: `IFR <= (IFR & ~w1c) | event`.
- A simultaneous W1C and event on the same bit leaves the flag set; set wins.
- A level trigger re-sets its flag every cycle while the level persists.
- Clearing `IMR` does not clear `IFR`.

Interrupt: `irq <= |(IFR & IMR)`, registered.

Bus handshake:
- A new access is accepted on the edge where `wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o`.
- On that edge, the write is committed, `wb_dat_o` is loaded, and `wb_ack_o` or `wb_err_o` rises.
- The ack or err is high for exactly one cycle, then forced low. A held strobe is therefore serviced every second cycle.
- Dropping `wb_cyc_i` while ack is high has no further effect.

## Timing
- Reset (async assert, sync deassert externally): all registers, synchroniser flops, `s_d`, `wb_dat_o`, `wb_ack_o`, `wb_err_o`, `gpio_o`, `gpio_oe` and `irq` are 0 immediately.
- A pin held high through reset produces a rise `SYNC_STAGES` cycles after reset. It sets no flag because `IMR`=0.
- Access latency: ack/err appears 1 cycle after the strobe is seen. Read data is valid with ack.
- `gpio_o` and `gpio_oe` change on the same edge that asserts ack for the write.
- Pin change to `DATA` readback: the change appears in `s` after `SYNC_STAGES` edges. The read then samples it on its accept edge.
- Pin edge to `IFR` set: `SYNC_STAGES + 1` edges.
- `IFR` set to `irq` high: 1 edge.
- W1C of the last pending masked flag: `irq` falls 1 edge after the ack edge.
- Reset asserted mid-access: ack is dropped at once. No partial write survives.

## Test plan
- Reset, then read every mapped offset, then write 0xFFFFFFFF to every register and read back, with `WIDTH`=32 and then `WIDTH`=8.
  - After reset: all reads 0, all outputs 0.
  - With `WIDTH`=8: bits [31:8] read 0.
- Write DDR=0x0000_00FF and DATA=0x0000_00A5. Then SET 0x0A, CLR 0x01, TGL 0xF0.
  - `gpio_o` follows 0xA5, 0xAF, 0xAE, 0x5E.
  - Each step is visible on the ack edge.
- Write DATA=0x1234_5678 with `wb_sel_i`=4'b0010. Latch = 0x0000_5600.
- Pin 3 as input, IMR bit 3 = 1, IER=1, IPR=1. Drive a 0→1 edge.
  - IFR = 0x8 after `SYNC_STAGES+1` edges; `irq` rises 1 edge later.
  - A 1→0 edge sets no flag.
  - Then set IBE=1: a 1→0 edge sets the flag.
- Level-low trigger on pin 0, pin held low. W1C 0x1: IFR bit 0 reads 1 again on the next read.
  - W1C on the same cycle as an edge event: the flag stays 1.
- Read offset 0x28, then write offset 0xFC.
  - Each returns `wb_err_o` for 1 cycle, no ack, and no register change.
  - A strobe held for 6 cycles on offset 0x00 gets 3 ack pulses.
